// File: rtl/register_file_param.sv
// Parametrised register file: one write port, two registered read ports (1-cycle latency), hardware clear sequencer.
// Optional same-edge write-to-read bypass when REGFILE_BYPASS_EN is defined; no backpressure, clear_busy flags dropped accesses.
module register_file_param #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] write_register,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_register1,
   input  logic [ADDR_W-1:0] read_register2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   input  logic              clear_start,
   output logic              clear_busy
);

   localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  LP_DEPTH = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LP_LAST  = IDX_W'(DEPTH - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd1;
   logic [DATA_W-1:0] r_rd2;

   logic              w_idle;
   logic              w_clr_we;
   logic              w_wr_ok;
   logic              w_rd1_ok;
   logic              w_rd2_ok;
   logic [IDX_W-1:0]  w_wa;
   logic [IDX_W-1:0]  w_ra1;
   logic [IDX_W-1:0]  w_ra2;
   logic [DATA_W-1:0] w_rd1_nxt;
   logic [DATA_W-1:0] w_rd2_nxt;

   assign w_wr_ok  = ({1'b0, write_register} < LP_DEPTH);
   assign w_rd1_ok = ({1'b0, read_register1} < LP_DEPTH);
   assign w_rd2_ok = ({1'b0, read_register2} < LP_DEPTH);
   assign w_wa     = write_register[IDX_W-1:0];
   assign w_ra1    = read_register1[IDX_W-1:0];
   assign w_ra2    = read_register2[IDX_W-1:0];

   // State register; the clear index rests at 0 whenever the sequencer is idle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_CLEAR;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_CLEAR) begin
            r_idx <= (r_idx == LP_LAST) ? '0 : r_idx + IDX_W'(1);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (clear_start) w_state_nxt = S_CLEAR;
         S_CLEAR: if (r_idx == LP_LAST) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_CLEAR;
      endcase
   end

   always_comb begin
      w_idle     = (r_state == S_IDLE);
      w_clr_we   = (r_state == S_CLEAR);
      clear_busy = (r_state == S_CLEAR);
   end

   // Storage has no reset; the clear sequencer zeroes it after every reset.
   always_ff @(posedge clock) begin
      if (w_clr_we) begin
         r_mem[r_idx] <= '0;
      end else if (w_idle && reg_write && w_wr_ok) begin
         r_mem[w_wa] <= write_data;
      end
   end

   always_comb begin
      w_rd1_nxt = '0;
      w_rd2_nxt = '0;
      if (w_idle) begin
         if (w_rd1_ok) w_rd1_nxt = r_mem[w_ra1];
         if (w_rd2_ok) w_rd2_nxt = r_mem[w_ra2];
`ifdef REGFILE_BYPASS_EN
         if (reg_write && w_wr_ok && (write_register == read_register1)) w_rd1_nxt = write_data;
         if (reg_write && w_wr_ok && (write_register == read_register2)) w_rd2_nxt = write_data;
`endif
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rd1 <= '0;
         r_rd2 <= '0;
      end else begin
         r_rd1 <= w_rd1_nxt;
         r_rd2 <= w_rd2_nxt;
      end
   end

   assign read_data1 = r_rd1;
   assign read_data2 = r_rd2;

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: default 32-entry instance plus a 20-entry instance for out-of-range addressing.
module tb_register_file_param;

   localparam int D  = 32;
   localparam int BD = 20;

   logic       clock;
   logic       reset_n;
   logic       reg_write;
   logic [4:0] write_register;
   logic [3:0] write_data;
   logic [4:0] read_register1;
   logic [4:0] read_register2;
   logic [3:0] read_data1;
   logic [3:0] read_data2;
   logic       clear_start;
   logic       clear_busy;

   logic       b_reg_write;
   logic [4:0] b_write_register;
   logic [3:0] b_write_data;
   logic [4:0] b_read_register1;
   logic [4:0] b_read_register2;
   logic [3:0] b_read_data1;
   logic [3:0] b_read_data2;
   logic       b_clear_start;
   logic       b_clear_busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: plain array plus count of clear cycles still to run.
   int       m_mem [D];
   int       m_busy_left;
   logic [3:0] m_rd1;
   logic [3:0] m_rd2;

   register_file_param #(.DATA_W(4), .ADDR_W(5), .DEPTH(D)) dut (
      .clock(clock), .reset_n(reset_n), .reg_write(reg_write),
      .write_register(write_register), .write_data(write_data),
      .read_register1(read_register1), .read_register2(read_register2),
      .read_data1(read_data1), .read_data2(read_data2),
      .clear_start(clear_start), .clear_busy(clear_busy)
   );

   register_file_param #(.DATA_W(4), .ADDR_W(5), .DEPTH(BD)) dut_b (
      .clock(clock), .reset_n(reset_n), .reg_write(b_reg_write),
      .write_register(b_write_register), .write_data(b_write_data),
      .read_register1(b_read_register1), .read_register2(b_read_register2),
      .read_data1(b_read_data1), .read_data2(b_read_data2),
      .clear_start(b_clear_start), .clear_busy(b_clear_busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic void model_step();
      logic [3:0] n1;
      logic [3:0] n2;
      if (m_busy_left > 0) begin
         m_mem[D - m_busy_left] = 0;
         m_busy_left = m_busy_left - 1;
         m_rd1 = 4'h0;
         m_rd2 = 4'h0;
      end else begin
         n1 = (int'(read_register1) < D) ? 4'(m_mem[read_register1]) : 4'h0;
         n2 = (int'(read_register2) < D) ? 4'(m_mem[read_register2]) : 4'h0;
`ifdef REGFILE_BYPASS_EN
         if (reg_write && write_register == read_register1) n1 = write_data;
         if (reg_write && write_register == read_register2) n2 = write_data;
`endif
         if (reg_write && int'(write_register) < D) m_mem[write_register] = int'(write_data);
         if (clear_start) m_busy_left = D;
         m_rd1 = n1;
         m_rd2 = n2;
      end
   endfunction

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      int busy_cnt;
      reset_n = 1'b0;
      reg_write = 1'b0; write_register = '0; write_data = '0;
      read_register1 = '0; read_register2 = '0; clear_start = 1'b0;
      b_reg_write = 1'b0; b_write_register = '0; b_write_data = '0;
      b_read_register1 = '0; b_read_register2 = '0; b_clear_start = 1'b0;
      for (int i = 0; i < D; i++) m_mem[i] = 0;
      m_busy_left = D; m_rd1 = 4'h0; m_rd2 = 4'h0;
      repeat (2) @(posedge clock);
      #1;
      n_cmp++;
      if (read_data1 !== 4'h0 || read_data2 !== 4'h0 || clear_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_state: rd1=%h rd2=%h busy=%b, want 0 0 1", read_data1, read_data2, clear_busy);
      end
      reset_n = 1'b1;
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (clear_busy === 1'b1) busy_cnt++;
         read_register1 = 5'($urandom_range(0, 31));
         read_register2 = 5'($urandom_range(0, 31));
         tick();
         n_cmp++;
         if (read_data1 !== m_rd1 || read_data2 !== m_rd2 || clear_busy !== (m_busy_left > 0)) begin
            n_bad++;
            $display("FAIL reset_clear_cycle %0d: rd1=%h rd2=%h busy=%b, want %h %h %b",
                     i, read_data1, read_data2, clear_busy, m_rd1, m_rd2, m_busy_left > 0);
         end
      end
      n_cmp++;
      if (busy_cnt != D) begin
         n_bad++;
         $display("FAIL reset_busy_len: got %0d cycles, want %0d", busy_cnt, D);
      end
      for (int a = 0; a < D; a++) begin
         read_register1 = 5'(a);
         read_register2 = 5'(D - 1 - a);
         tick();
         n_cmp++;
         if (read_data1 !== 4'h0 || read_data2 !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_zero r%0d: rd1=%h rd2=%h, want 0 0", a, read_data1, read_data2);
         end
      end
   endtask

   task automatic test_write_read();
      reg_write = 1'b1; write_register = 5'd7; write_data = 4'h5;
      tick();
      write_register = 5'd3; write_data = 4'hA;
      tick();
      reg_write = 1'b0; read_register1 = 5'd3; read_register2 = 5'd7;
      tick();
      n_cmp++;
      if (read_data1 !== 4'hA || read_data2 !== 4'h5) begin
         n_bad++;
         $display("FAIL write_read_r3_r7: rd1=%h rd2=%h, want a 5", read_data1, read_data2);
      end
      for (int i = 0; i < 200; i++) begin
         reg_write      = 1'($urandom_range(0, 1));
         write_register = 5'($urandom_range(0, 31));
         write_data     = 4'($urandom_range(0, 15));
         read_register1 = 5'($urandom_range(0, 31));
         read_register2 = ($urandom_range(0, 3) == 0) ? read_register1 : 5'($urandom_range(0, 31));
         tick();
         n_cmp++;
         if (read_data1 !== m_rd1 || read_data2 !== m_rd2 || clear_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL random_rw %0d: rd1=%h rd2=%h busy=%b, want %h %h 0",
                     i, read_data1, read_data2, clear_busy, m_rd1, m_rd2);
         end
      end
      reg_write = 1'b0;
   endtask

   task automatic test_same_cycle();
      logic [3:0] exp_first;
`ifdef REGFILE_BYPASS_EN
      exp_first = 4'hC;
`else
      exp_first = 4'h2;
`endif
      reg_write = 1'b1; write_register = 5'd9; write_data = 4'h2;
      tick();
      write_data = 4'hC; read_register1 = 5'd9; read_register2 = 5'd9;
      tick();
      n_cmp++;
      if (read_data1 !== exp_first || read_data2 !== exp_first) begin
         n_bad++;
         $display("FAIL same_cycle_rw: rd1=%h rd2=%h, want %h", read_data1, read_data2, exp_first);
      end
      reg_write = 1'b0;
      tick();
      n_cmp++;
      if (read_data1 !== 4'hC || read_data2 !== 4'hC) begin
         n_bad++;
         $display("FAIL same_cycle_next: rd1=%h rd2=%h, want c", read_data1, read_data2);
      end
   endtask

   task automatic test_clear_start();
      int busy_cnt;
      reg_write = 1'b1; write_data = 4'hF;
      for (int a = 0; a < D; a++) begin
         write_register = 5'(a);
         tick();
      end
      reg_write = 1'b0; read_register1 = 5'd0; read_register2 = 5'd31;
      tick();
      n_cmp++;
      if (read_data1 !== 4'hF || read_data2 !== 4'hF) begin
         n_bad++;
         $display("FAIL fill_all: rd1=%h rd2=%h, want f", read_data1, read_data2);
      end
      clear_start = 1'b1; reg_write = 1'b1; write_register = 5'd4; write_data = 4'h3;
      tick();
      clear_start = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (clear_busy === 1'b1) busy_cnt++;
         reg_write      = (m_busy_left > 0);
         clear_start    = (m_busy_left > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         write_register = 5'($urandom_range(0, 31));
         write_data     = 4'($urandom_range(1, 15));
         read_register1 = 5'($urandom_range(0, 31));
         read_register2 = 5'($urandom_range(0, 31));
         tick();
         n_cmp++;
         if (read_data1 !== m_rd1 || read_data2 !== m_rd2 || clear_busy !== (m_busy_left > 0)) begin
            n_bad++;
            $display("FAIL clear_cycle %0d: rd1=%h rd2=%h busy=%b, want %h %h %b",
                     i, read_data1, read_data2, clear_busy, m_rd1, m_rd2, m_busy_left > 0);
         end
      end
      reg_write = 1'b0; clear_start = 1'b0;
      n_cmp++;
      if (busy_cnt != D) begin
         n_bad++;
         $display("FAIL clear_busy_len: got %0d cycles, want %0d", busy_cnt, D);
      end
      for (int a = 0; a < D; a++) begin
         read_register1 = 5'(a);
         read_register2 = 5'(a);
         tick();
         n_cmp++;
         if (read_data1 !== 4'h0 || read_data2 !== 4'h0) begin
            n_bad++;
            $display("FAIL clear_zero r%0d: rd1=%h rd2=%h, want 0 0", a, read_data1, read_data2);
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      int busy_cnt;
      reg_write = 1'b1; write_register = 5'd12; write_data = 4'h6;
      tick();
      reg_write = 1'b0; clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      repeat (10) tick();
      reset_n = 1'b0;
      m_busy_left = D; m_rd1 = 4'h0; m_rd2 = 4'h0;
      #2;
      n_cmp++;
      if (read_data1 !== 4'h0 || read_data2 !== 4'h0 || clear_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_clear_reset: rd1=%h rd2=%h busy=%b, want 0 0 1", read_data1, read_data2, clear_busy);
      end
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (clear_busy === 1'b1) busy_cnt++;
         read_register1 = 5'($urandom_range(0, 31));
         read_register2 = 5'd12;
         tick();
         n_cmp++;
         if (read_data1 !== m_rd1 || read_data2 !== m_rd2 || clear_busy !== (m_busy_left > 0)) begin
            n_bad++;
            $display("FAIL restart_cycle %0d: rd1=%h rd2=%h busy=%b, want %h %h %b",
                     i, read_data1, read_data2, clear_busy, m_rd1, m_rd2, m_busy_left > 0);
         end
      end
      n_cmp++;
      if (busy_cnt != D) begin
         n_bad++;
         $display("FAIL restart_busy_len: got %0d cycles, want %0d", busy_cnt, D);
      end
   endtask

   task automatic test_out_of_range();
      logic [3:0] bm [BD];
      int         waited;
      waited = 0;
      while (b_clear_busy !== 1'b0 && waited < 100) begin
         tick();
         waited++;
      end
      n_cmp++;
      if (b_clear_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL b_clear_timeout: busy=%b after %0d cycles, want 0", b_clear_busy, waited);
      end
      b_reg_write = 1'b1;
      for (int a = 0; a < BD; a++) begin
         bm[a] = 4'($urandom_range(0, 15));
         b_write_register = 5'(a);
         b_write_data = bm[a];
         tick();
      end
      b_write_register = 5'd25; b_write_data = 4'h7;
      tick();
      b_reg_write = 1'b0; b_read_register1 = 5'd25; b_read_register2 = 5'd31;
      tick();
      n_cmp++;
      if (b_read_data1 !== 4'h0 || b_read_data2 !== 4'h0) begin
         n_bad++;
         $display("FAIL oob_read: rd1=%h rd2=%h, want 0 0", b_read_data1, b_read_data2);
      end
      for (int a = 0; a < BD; a++) begin
         b_read_register1 = 5'(a);
         b_read_register2 = 5'(BD - 1 - a);
         tick();
         n_cmp++;
         if (b_read_data1 !== bm[a] || b_read_data2 !== bm[BD - 1 - a]) begin
            n_bad++;
            $display("FAIL oob_keep r%0d: rd1=%h rd2=%h, want %h %h",
                     a, b_read_data1, b_read_data2, bm[a], bm[BD - 1 - a]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_same_cycle();
      test_clear_start();
      test_reset_mid_clear();
      test_out_of_range();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1);
   end

endmodule
